// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer.
// in_ready depends only on registered state, so out_ready never
// reaches in_ready combinationally. Entries leave in strict arrival order.
module mem_wb_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WB_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   WB,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [ADDR_W-1:0] RegDst_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   _WB,
    output logic [DATA_W-1:0] _read_data,
    output logic [DATA_W-1:0] _ALU_result,
    output logic [ADDR_W-1:0] _RegDst_address,
    output logic [DATA_W-1:0] wb_data,
    output logic              reg_write
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] alu;
        logic [ADDR_W-1:0] dst;
    } entry_t;

    entry_t main_q, skid_q, main_d, skid_d, in_entry;
    logic   main_valid, skid_valid, main_valid_d, skid_valid_d;
    logic   accept, pop;

    // Incoming payload and handshake terms
    always_comb begin
        in_entry.wb  = WB;
        in_entry.rd  = read_data;
        in_entry.alu = ALU_result;
        in_entry.dst = RegDst_address;
        accept       = in_valid & ~skid_valid;
        pop          = main_valid & out_ready;
    end

    // Next state: flush discards everything; otherwise pop refills main
    // from skid (or input), and a blocked accept lands in skid
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                // accept cannot happen here: in_ready is low while skid is full
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    // State registers; reset clears flags and payloads
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    // Outputs straight from the main entry; write-back select and enable
    always_comb begin
        in_ready        = ~skid_valid;
        out_valid       = main_valid;
        _WB             = main_q.wb;
        _read_data      = main_q.rd;
        _ALU_result     = main_q.alu;
        _RegDst_address = main_q.dst;
        wb_data         = main_q.wb[1] ? main_q.rd : main_q.alu;
        reg_write       = main_valid & main_q.wb[0] & (main_q.dst != '0);
    end

endmodule
